// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the immediate generator: mode encodings, field widths
// and per-mode shift / zero-extend lookups.
package imm_gen_pipe_pkg;

  typedef enum logic [2:0] {
    MODE_IMM5  = 3'd0,
    MODE_BOFF6 = 3'd1,
    MODE_PC9   = 3'd2,
    MODE_PC11  = 3'd3,
    MODE_OFF6  = 3'd4,
    MODE_TRAP8 = 3'd5,
    MODE_RSV6  = 3'd6,
    MODE_RSV7  = 3'd7
  } mode_e;

  localparam int FW_IMM5  = 5;
  localparam int FW_BOFF6 = 6;
  localparam int FW_PC9   = 9;
  localparam int FW_PC11  = 11;
  localparam int FW_OFF6  = 6;
  localparam int FW_TRAP8 = 8;

  // Shifted modes are also the only ones where the LSB force applies.
  function automatic logic mode_shift(input mode_e m);
    return (m inside {MODE_PC9, MODE_PC11, MODE_OFF6, MODE_TRAP8});
  endfunction

  function automatic logic mode_zext(input mode_e m);
    return (m == MODE_TRAP8);
  endfunction

  function automatic logic mode_reserved(input mode_e m);
    return (m inside {MODE_RSV6, MODE_RSV7});
  endfunction

endpackage

// File: rtl/imm_gen_pipe_field_ext.sv
// Combinational field select, sign/zero extension, optional shift-by-1 and
// LSB force for one instruction word.
module imm_field_ext
  import imm_gen_pipe_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int INSTR_W = 16
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [2:0]         mode,
  input  logic               set_lsb,
  output logic [DATA_W-1:0]  ext,
  output logic               err
);

  mode_e             m;
  logic              zext;
  logic              fill;
  logic [DATA_W-1:0] raw;

  assign m    = mode_e'(mode);
  assign zext = mode_zext(m);

  always_comb begin
    raw  = '0;
    fill = 1'b0;
    err  = mode_reserved(m);
    case (m)
      MODE_IMM5: begin
        fill = !zext && instr[FW_IMM5-1];
        raw  = {{(DATA_W-FW_IMM5){fill}}, instr[FW_IMM5-1:0]};
      end
      MODE_BOFF6: begin
        fill = !zext && instr[FW_BOFF6-1];
        raw  = {{(DATA_W-FW_BOFF6){fill}}, instr[FW_BOFF6-1:0]};
      end
      MODE_PC9: begin
        fill = !zext && instr[FW_PC9-1];
        raw  = {{(DATA_W-FW_PC9){fill}}, instr[FW_PC9-1:0]};
      end
      MODE_PC11: begin
        fill = !zext && instr[FW_PC11-1];
        raw  = {{(DATA_W-FW_PC11){fill}}, instr[FW_PC11-1:0]};
      end
      MODE_OFF6: begin
        fill = !zext && instr[FW_OFF6-1];
        raw  = {{(DATA_W-FW_OFF6){fill}}, instr[FW_OFF6-1:0]};
      end
      MODE_TRAP8: begin
        fill = !zext && instr[FW_TRAP8-1];
        raw  = {{(DATA_W-FW_TRAP8){fill}}, instr[FW_TRAP8-1:0]};
      end
      default: raw = '0;
    endcase
  end

  // The shift vacates bit 0, so forcing the LSB is just filling it with set_lsb.
  always_comb begin
    ext = raw;
    if (mode_shift(m)) begin
      ext = {raw[DATA_W-2:0], set_lsb};
    end
  end

  generate
    if (INSTR_W > FW_PC11) begin : g_hi_bits
      logic unused_instr_hi;
      assign unused_instr_hi = ^instr[INSTR_W-1:FW_PC11];
    end
  endgenerate

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage immediate/offset generator: s1 holds the extended field, s2 holds
// the final (optionally base-added) result presented to the consumer.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [2:0]         in_mode,
  input  logic               in_set_lsb,
  input  logic               in_add_base,
  input  logic [DATA_W-1:0]  in_base,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_carry,
  output logic               out_err
);

  // Handshake: a transfer happens on a rising edge where valid && ready; a
  // producer holds valid and payload until that edge, and ready may depend
  // combinationally on the downstream ready (no skid buffer).

  logic [DATA_W-1:0] f_ext;
  logic              f_err;

  imm_field_ext #(
    .DATA_W  (DATA_W),
    .INSTR_W (INSTR_W)
  ) u_field_ext (
    .instr   (in_instr),
    .mode    (in_mode),
    .set_lsb (in_set_lsb),
    .ext     (f_ext),
    .err     (f_err)
  );

  logic              s1_valid;
  logic [DATA_W-1:0] s1_ext;
  logic              s1_err;
  logic              s1_add_base;
  logic [DATA_W-1:0] s1_base;

  logic              s2_valid;
  logic              s2_adv;
  logic [DATA_W:0]   sum;

  assign s2_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_adv;
  assign out_valid = s2_valid;

  // Reserved modes extend to zero, so the add naturally yields the base.
  assign sum = {1'b0, s1_ext} + {1'b0, s1_base};

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_ext      <= '0;
      s1_err      <= 1'b0;
      s1_add_base <= 1'b0;
      s1_base     <= '0;
      s2_valid    <= 1'b0;
      out_data    <= '0;
      out_carry   <= 1'b0;
      out_err     <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data  <= s1_add_base ? sum[DATA_W-1:0] : s1_ext;
          out_carry <= s1_add_base && sum[DATA_W];
          out_err   <= s1_err;
        end
      end
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_ext      <= f_ext;
          s1_err      <= f_err;
          s1_add_base <= in_add_base;
          s1_base     <= in_base;
        end
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomized and directed bench for imm_gen_pipe with a behavioural model and
// an expected-result queue checked every cycle.
module tb_imm_gen_pipe;

  localparam int DW = 16;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_instr;
  logic [2:0]    in_mode;
  logic          in_set_lsb;
  logic          in_add_base;
  logic [DW-1:0] in_base;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_carry;
  logic          out_err;

  always #5 clk = ~clk;

  imm_gen_pipe #(.DATA_W(DW), .INSTR_W(IW)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_mode     (in_mode),
    .in_set_lsb  (in_set_lsb),
    .in_add_base (in_add_base),
    .in_base     (in_base),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_carry   (out_carry),
    .out_err     (out_err)
  );

  int total = 0;
  int bad   = 0;
  logic [DW+1:0] exp_q[$];  // {err, carry, data}
  bit rnd_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain arithmetic reference: field value, signed interpretation, *2, +1, mod 2^DW.
  function automatic logic [DW+1:0] model(input logic [IW-1:0] instr, input logic [2:0] mode,
                                          input logic lsb, input logic add, input logic [DW-1:0] base);
    int     w;
    bit     sh;
    bit     zx;
    bit     err;
    longint v;
    longint ext;
    longint s;
    w = 0; sh = 0; zx = 0; err = 0;
    case (mode)
      3'd0: w = 5;
      3'd1: w = 6;
      3'd2: begin w = 9;  sh = 1; end
      3'd3: begin w = 11; sh = 1; end
      3'd4: begin w = 6;  sh = 1; end
      3'd5: begin w = 8;  sh = 1; zx = 1; end
      default: err = 1;
    endcase
    if (err) begin
      v = 0;
    end else begin
      v = longint'(instr) & ((longint'(1) << w) - 1);
      if (!zx && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
      if (sh) v = v * 2;
      if (sh && lsb) v = v + 1;
    end
    ext = v & ((longint'(1) << DW) - 1);
    s   = ext + (add ? longint'(base) : 0);
    model = {err, add ? s[DW] : 1'b0, s[DW-1:0]};
  endfunction

  // Compare process: in_ready rule, output hold under stall, in-order results.
  bit            hold_v = 1'b0;
  logic [DW+1:0] hold_d;
  always @(negedge clk) begin : monitor
    int n;
    if (reset) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      n = exp_q.size();
      check("in_ready", {31'd0, in_ready}, {31'd0, !(n == 2 && !out_ready)});
      if (hold_v) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data", {14'd0, out_err, out_carry, out_data}, {14'd0, hold_d});
      end
      hold_v = out_valid && !out_ready;
      hold_d = {out_err, out_carry, out_data};
      if (out_valid && out_ready) begin
        if (n == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out: got data %h with nothing outstanding at %0t", out_data, $time);
        end else begin
          check("out_result", {14'd0, out_err, out_carry, out_data}, {14'd0, exp_q.pop_front()});
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(in_instr, in_mode, in_set_lsb, in_add_base, in_base));
    end
  end

  task automatic send(input logic [IW-1:0] i, input logic [2:0] m, input logic l,
                      input logic a, input logic [DW-1:0] b);
    bit done;
    done = 1'b0;
    in_instr = i; in_mode = m; in_set_lsb = l; in_add_base = a; in_base = b;
    in_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready stayed 0 for 200 cycles, want 1");
    end
  endtask

  task automatic drain();
    bit empty;
    empty = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 200 && !empty; k++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) empty = 1'b1;
    end
    if (!empty) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d results outstanding, want 0", exp_q.size());
    end
  endtask

  initial begin : rnd_ready
    forever begin
      @(posedge clk);
      #1;
      if (rnd_on) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_mode = '0;
    in_set_lsb = 1'b0; in_add_base = 1'b0; in_base = '0; out_ready = 1'b1;

    // Pin the model with hand-computed values.
    check("pin_imm5",  {14'd0, model(16'h001F, 3'd0, 1'b0, 1'b0, 16'h0000)}, {14'd0, 2'b00, 16'hFFFF});
    check("pin_pc9",   {14'd0, model(16'h0100, 3'd2, 1'b0, 1'b1, 16'h3000)}, {14'd0, 2'b01, 16'h2E00});
    check("pin_trap0", {14'd0, model(16'h0025, 3'd5, 1'b0, 1'b0, 16'h0000)}, {14'd0, 2'b00, 16'h004A});
    check("pin_trap1", {14'd0, model(16'h0025, 3'd5, 1'b1, 1'b0, 16'h0000)}, {14'd0, 2'b00, 16'h004B});
    check("pin_boff",  {14'd0, model(16'h0020, 3'd1, 1'b1, 1'b0, 16'h0000)}, {14'd0, 2'b00, 16'hFFE0});
    check("pin_rsv",   {14'd0, model(16'hFFFF, 3'd6, 1'b1, 1'b1, 16'h1234)}, {14'd0, 2'b10, 16'h1234});

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {16'd0, out_data}, 32'd0);
    check("rst_out_carry", {31'd0, out_carry}, 32'd0);
    check("rst_out_err",   {31'd0, out_err}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Latency: result visible two cycles after the transfer cycle.
    send(16'h001F, 3'd0, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    check("lat_c1_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_c2_valid", {31'd0, out_valid}, 32'd1);
    check("lat_c2_data",  {16'd0, out_data}, 32'h0000FFFF);
    @(posedge clk);
    #1;

    send(16'h0100, 3'd2, 1'b0, 1'b1, 16'h3000);
    send(16'h0025, 3'd5, 1'b0, 1'b0, 16'h0000);
    send(16'h0025, 3'd5, 1'b1, 1'b0, 16'h0000);
    send(16'h0020, 3'd1, 1'b1, 1'b0, 16'h0000);
    drain();

    // Back-pressure: third offer stalls while both stages are full.
    out_ready = 1'b0;
    send(16'h0003, 3'd0, 1'b0, 1'b0, 16'h0000);
    send(16'h002A, 3'd1, 1'b0, 1'b0, 16'h0000);
    fork
      send(16'h0400, 3'd3, 1'b0, 1'b0, 16'h0000);
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready",  {31'd0, in_ready}, 32'd0);
          check("bp_hold_data", {16'd0, out_data}, 32'h00000003);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reserved mode with base add, then a normal transaction clears err.
    send(16'hFFFF, 3'd6, 1'b1, 1'b1, 16'h1234);
    @(negedge clk);
    @(negedge clk);
    check("rsv_data", {16'd0, out_data}, 32'h00001234);
    check("rsv_err",  {31'd0, out_err}, 32'd1);
    @(posedge clk);
    #1;
    send(16'h0001, 3'd0, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    check("after_rsv_err", {31'd0, out_err}, 32'd0);
    drain();

    // Reset with both stages full discards everything.
    out_ready = 1'b0;
    send(16'h0011, 3'd4, 1'b1, 1'b1, 16'h0101);
    send(16'h0222, 3'd3, 1'b0, 1'b1, 16'hF000);
    @(negedge clk);
    check("prerst_full", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_valid",    {31'd0, out_valid}, 32'd0);
    check("midrst_data",     {16'd0, out_data}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (5) @(posedge clk);
    #1;

    // Randomized traffic with random back-pressure.
    rnd_on = 1'b1;
    for (int t = 0; t < 400; t++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(IW'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), DW'($urandom));
    end
    rnd_on = 1'b0;
    @(posedge clk);
    #2;
    drain();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate/offset generator for the datapath; the next generation of the combinational extension unit.
- Decodes an instruction word, selects the immediate field by mode, sign/zero-extends to DATA_W, optionally shifts left by 1, optionally forces the LSB, and optionally adds a base value (PC or register).
- Sits between decode and the address/ALU operand muxes.
- Uses a 2-stage valid/ready pipeline so back-pressure from the execute stage stalls it cleanly.

Parameters:
DATA_W, 16, output/base width; legal range 12..32.
INSTR_W, 16, instruction word width; must be >= 11.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  input transaction valid.
in_ready  output  1  stage 1 can accept a transaction this cycle.
in_instr  input  INSTR_W  instruction word; fields taken from the low bits.
in_mode  input  3  field select (see Behaviour).
in_set_lsb  input  1  force bit 0 of the extended value to 1 (shifted modes only).
in_add_base  input  1  1 = out_data is ext + in_base; 0 = out_data is ext.
in_base  input  DATA_W  base operand.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
out_data  output  DATA_W  result.
out_carry  output  1  carry out of the base add; 0 when in_add_base=0.
out_err  output  1  transaction used a reserved mode.

Behaviour:
- Handshake and latency
  - Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
  - Latency is exactly 2 cycles from input transfer to out_valid with no stall. Throughput is 1 per cycle.
- Mode encoding (extension uses in_instr bits):
  - 0 IMM5: [4:0] sign-extended, no shift.
  - 1 BOFF6: [5:0] sign-extended, no shift.
  - 2 PC9: [8:0] sign-extended, shift 1.
  - 3 PC11: [10:0] sign-extended, shift 1.
  - 4 OFF6: [5:0] sign-extended, shift 1.
  - 5 TRAP8: [7:0] zero-extended, shift 1.
  - 6, 7 reserved: ext = 0, err = 1.
- Shift and LSB
  - The shift result is truncated to DATA_W.
  - in_set_lsb ORs 1 into bit 0 only for modes 2..5; it is ignored for modes 0, 1 and the reserved modes.
- Stage 1 (s1) registers ext, err, add_base and base.
- Stage 2 (s2) registers data = add_base ? (ext + base) mod 2^DATA_W : ext, and carry = add_base ? bit DATA_W of the (DATA_W+1)-bit sum : 0.
  - For a reserved mode with add_base=1, data = base and err = 1.
- Flow control
  - s2_adv = !s2_valid || out_ready.
  - in_ready = !s1_valid || s2_adv (combinational from out_ready; no skid buffer).
  - When s2 is full and out_ready=0: out_data, out_carry and out_err hold stable, and s1 holds its contents.
  - Simultaneous drain of s2 and load of s1 is allowed in the same cycle with no bubble.
  - Transaction order is always preserved.
- Reset
  - s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_carry=0, out_err=0; in_ready=1 in the first cycle after reset deasserts.
  - Reset asserted mid-operation discards all in-flight transactions, with no partial output.
  - Inputs are ignored while reset=1.
- out_err is per-transaction, not sticky.

Decomposition:
- Shared package: mode encodings (MODE_IMM5..MODE_TRAP8, MODE_RSV6/7), field widths (5, 6, 9, 11, 6, 8), the shift-flag and zero-extend-flag lookup per mode.
- One sub-module, imm_field_ext: a purely combinational mode decode, extend, shift and LSB force producing {ext, err}.
- The pipeline registers and handshake live in imm_gen_pipe.

Test Plan (DATA_W=16, INSTR_W=16):
- Mode 0, instr=16'h001F, add_base=0, out_ready=1 -> out_valid in cycle +2, out_data=16'hFFFF, carry=0, err=0.
- Mode 2, instr[8:0]=9'h100, add_base=1, base=16'h3000 -> out_data=16'h2E00 (ext 16'hFE00), carry=1.
- Mode 5, instr[7:0]=8'h25: set_lsb=0 -> 16'h004A; set_lsb=1 -> 16'h004B. Mode 1, instr[5:0]=6'h20, set_lsb=1 -> 16'hFFE0 (LSB unaffected).
- Back-pressure: out_ready=0 for 4 cycles while 3 transactions (modes 0, 1, 3) are offered back-to-back -> 2 accepted, then in_ready=0; out_data held constant; after out_ready=1, outputs emerge in order with no loss or duplication.
- Mode 6 with add_base=1, base=16'h1234 -> out_data=16'h1234, err=1; the next mode-0 transaction -> err=0.
- Reset asserted for 1 cycle with both stages full -> next cycle out_valid=0, out_data=0, in_ready=1; no stale result appears afterwards.
